// File: rtl/sky130_fd_io__hvc_pwrgood_seq.sv
// Power-good sequencer for an HVC IO power pad.
//
// Each rail-OK detector output is brought into the CLK domain through a
// 2-flop synchronizer and then debounced. A small FSM walks through
// OFF -> WAIT_IO -> WAIT_CORE -> SETTLE -> GOOD. It latches FAULT if a
// filtered rail drops while in SETTLE or GOOD.
//
// Parameters:
//   DEBOUNCE_CYC  consecutive disagreeing cycles needed to flip a filtered rail
//   SETTLE_CYC    cycles both rails must stay good before PWRGOOD asserts
//   CNT_W         width of the debounce and settle counters
//
// Ports:
//   CLK           sequencer clock
//   RESET_B       async active-low reset; deassertion is synchronized inside
//   EN            sequencing enable (CLK-synchronous)
//   VDDIO_OK_RAW  async HV rail detector output
//   VCCD_OK_RAW   async core rail detector output
//   CLR_FAULT     synchronous fault-clear pulse
//   PWRGOOD       registered, 1 only in GOOD
//   HLD_H_N       registered IO hold release, 1 only in GOOD
//   FAULT         registered, 1 only in FAULT
//   STATE         current state code

// Per-rail synchronizer plus debouncer.
module sky130_fd_io__hvc_pwrgood_seq_filt #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // The counter stops at DEBOUNCE_CYC-1 and then either flips the filter or
  // clears, so it can never wrap.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_W'(DEBOUNCE_CYC - 1)) begin
      filt_d = sync_q[1];
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
endmodule

module sky130_fd_io__hvc_pwrgood_seq #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int SETTLE_CYC   = 64,
  parameter int CNT_W        = 8
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       EN,
  input  logic       VDDIO_OK_RAW,
  input  logic       VCCD_OK_RAW,
  input  logic       CLR_FAULT,
  output logic       PWRGOOD,
  output logic       HLD_H_N,
  output logic       FAULT,
  output logic [2:0] STATE
);
  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_WAIT_IO   = 3'd1,
    S_WAIT_CORE = 3'd2,
    S_SETTLE    = 3'd3,
    S_GOOD      = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  // Reset asserts asynchronously, releases two CLK edges after RESET_B rises.
  logic rst_meta_q, rst_sync_q, rst_n;
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end
  assign rst_n = rst_sync_q;

  // Bit 0 = VDDIO (io), bit 1 = VCCD (core).
  logic [1:0] raw, filt;
  assign raw = {VCCD_OK_RAW, VDDIO_OK_RAW};

  for (genvar g = 0; g < 2; g++) begin : g_rail
    sky130_fd_io__hvc_pwrgood_seq_filt #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_filt (
      .clk  (CLK),
      .rst_n(rst_n),
      .raw  (raw[g]),
      .filt (filt[g])
    );
  end

  logic io_f, core_f;
  assign io_f   = filt[0];
  assign core_f = filt[1];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic             pg_q, pg_d;
  logic             flt_q, flt_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      S_OFF:       if (EN) state_d = S_WAIT_IO;
      S_WAIT_IO: begin
        if (!EN)       state_d = S_OFF;
        else if (io_f) state_d = S_WAIT_CORE;
      end
      S_WAIT_CORE: begin
        // A lost IO rail wins over a simultaneous core-good: there is no
        // point settling with only one rail up.
        if (!EN)          state_d = S_OFF;
        else if (!io_f)   state_d = S_WAIT_IO;
        else if (core_f) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end
      S_SETTLE: begin
        if (!EN)                   state_d = S_OFF;
        else if (!io_f || !core_f) state_d = S_FAULT;
        else if (settle_q == CNT_W'(SETTLE_CYC - 1)) state_d = S_GOOD;
        else if (settle_q != '1)   settle_d = settle_q + 1'b1;
      end
      S_GOOD: begin
        if (!EN)                   state_d = S_OFF;
        else if (!io_f || !core_f) state_d = S_FAULT;
      end
      // Sticky: only an explicit clear leaves FAULT, EN is ignored here.
      S_FAULT:     if (CLR_FAULT) state_d = S_OFF;
      default:     state_d = S_OFF;
    endcase
    // Outputs are decoded from the next state so they track STATE exactly.
    pg_d  = (state_d == S_GOOD);
    flt_d = (state_d == S_FAULT);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      settle_q <= '0;
      pg_q     <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      pg_q     <= pg_d;
      flt_q    <= flt_d;
    end
  end

  assign STATE   = state_q;
  assign PWRGOOD = pg_q;
  assign HLD_H_N = pg_q;
  assign FAULT   = flt_q;
endmodule

// File: tb/tb_sky130_fd_io__hvc_pwrgood_seq.sv
module tb_sky130_fd_io__hvc_pwrgood_seq;
  logic       CLK = 1'b0;
  logic       RESET_B, EN, VDDIO_OK_RAW, VCCD_OK_RAW, CLR_FAULT;
  logic       PWRGOOD, HLD_H_N, FAULT;
  logic [2:0] STATE;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  sky130_fd_io__hvc_pwrgood_seq #(
    .DEBOUNCE_CYC(4),
    .SETTLE_CYC  (8),
    .CNT_W       (8)
  ) dut (
    .CLK         (CLK),
    .RESET_B     (RESET_B),
    .EN          (EN),
    .VDDIO_OK_RAW(VDDIO_OK_RAW),
    .VCCD_OK_RAW (VCCD_OK_RAW),
    .CLR_FAULT   (CLR_FAULT),
    .PWRGOOD     (PWRGOOD),
    .HLD_H_N     (HLD_H_N),
    .FAULT       (FAULT),
    .STATE       (STATE)
  );

  // Inputs are applied 1ns after a rising edge and held for n edges; the
  // outputs are then sampled 1ns after the last of those edges.
  typedef struct {
    logic       en, io, core, clr;
    int         n;
    logic [2:0] st;
    logic       pg, hld, flt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, io, core, clr, input int n,
                     input logic [2:0] st, input logic pg, hld, flt);
    vec_t v;
    v.en = en; v.io = io; v.core = core; v.clr = clr; v.n = n;
    v.st = st; v.pg = pg; v.hld = hld; v.flt = flt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [2:0] st,
                     input logic pg, hld, flt);
    logic [5:0] act, exp;
    act = {STATE, PWRGOOD, HLD_H_N, FAULT};
    exp = {st, pg, hld, flt};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got STATE=%0d PG=%b HLD=%b FLT=%b, want STATE=%0d PG=%b HLD=%b FLT=%b",
               name, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET_B = 1'b0; EN = 1'b0; VDDIO_OK_RAW = 1'b0; VCCD_OK_RAW = 1'b0; CLR_FAULT = 1'b0;

    // Main power-up: io rises at t0, core at t0+20.
    add(1, 1, 0, 0,  1, 3'd1, 0, 0, 0); // t0+1  WAIT_IO
    add(1, 1, 0, 0,  5, 3'd1, 0, 0, 0); // t0+6  io_f just rose
    add(1, 1, 0, 0,  1, 3'd2, 0, 0, 0); // t0+7  WAIT_CORE
    add(1, 1, 0, 0, 13, 3'd2, 0, 0, 0); // t0+20
    add(1, 1, 1, 0,  6, 3'd2, 0, 0, 0); // t0+26 core_f just rose
    add(1, 1, 1, 0,  1, 3'd3, 0, 0, 0); // t0+27 SETTLE
    add(1, 1, 1, 0,  7, 3'd3, 0, 0, 0); // t0+34 last settle cycle
    add(1, 1, 1, 0,  1, 3'd4, 1, 1, 0); // t0+35 GOOD
    add(1, 1, 1, 0,  5, 3'd4, 1, 1, 0);
    // 3-cycle io glitch is filtered out.
    add(1, 0, 1, 0,  3, 3'd4, 1, 1, 0);
    add(1, 1, 1, 0, 10, 3'd4, 1, 1, 0);
    // Core low for 10 cycles: filtered drop at +6, FAULT at +7.
    add(1, 1, 0, 0,  6, 3'd4, 1, 1, 0);
    add(1, 1, 0, 0,  1, 3'd5, 0, 0, 1);
    add(1, 1, 0, 0,  3, 3'd5, 0, 0, 1);
    add(1, 1, 1, 0, 12, 3'd5, 0, 0, 1); // rails recovered, still sticky
    add(1, 1, 1, 1,  1, 3'd0, 0, 0, 0); // clear
    add(1, 1, 1, 0,  1, 3'd1, 0, 0, 0);
    add(1, 1, 1, 0,  1, 3'd2, 0, 0, 0);
    add(1, 1, 1, 0,  1, 3'd3, 0, 0, 0);
    add(1, 1, 1, 0,  8, 3'd4, 1, 1, 0);
    // io drop lands in the same cycle EN goes low: EN wins.
    add(1, 0, 1, 0,  6, 3'd4, 1, 1, 0);
    add(0, 0, 1, 0,  1, 3'd0, 0, 0, 0);
    add(1, 0, 1, 0,  1, 3'd1, 0, 0, 0);

    step(3);
    chk("reset", 3'd0, 0, 0, 0);
    RESET_B = 1'b1;
    step(4);
    chk("idle_en0", 3'd0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      EN = tbl[i].en; VDDIO_OK_RAW = tbl[i].io; VCCD_OK_RAW = tbl[i].core;
      CLR_FAULT = tbl[i].clr;
      step(tbl[i].n);
      chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].pg, tbl[i].hld, tbl[i].flt);
    end

    // io toggling every 2 cycles never survives the debouncer.
    for (int k = 0; k < 10; k++) begin
      VDDIO_OK_RAW = 1'b1; step(2); chk($sformatf("toggle_hi%0d", k), 3'd1, 0, 0, 0);
      VDDIO_OK_RAW = 1'b0; step(2); chk($sformatf("toggle_lo%0d", k), 3'd1, 0, 0, 0);
    end

    // Reach SETTLE, then reset mid-SETTLE.
    VDDIO_OK_RAW = 1'b1;
    step(7); chk("rs_wait_core", 3'd2, 0, 0, 0);
    step(1); chk("rs_settle", 3'd3, 0, 0, 0);
    step(3); chk("rs_mid_settle", 3'd3, 0, 0, 0);
    #1 RESET_B = 1'b0;
    #1 chk("async_reset", 3'd0, 0, 0, 0);
    step(1); chk("reset_held", 3'd0, 0, 0, 0);
    #2 RESET_B = 1'b1;
    // Internal reset releases after the 2nd edge; the 3rd edge is the first
    // functional one, and the rails then need 2+4 cycles to re-filter.
    step(1); chk("rel_r1", 3'd0, 0, 0, 0);
    step(1); chk("rel_r2", 3'd0, 0, 0, 0);
    step(1); chk("rel_r3", 3'd1, 0, 0, 0);
    step(5); chk("rel_r8", 3'd1, 0, 0, 0);
    step(1); chk("rel_r9", 3'd2, 0, 0, 0);
    step(1); chk("rel_r10", 3'd3, 0, 0, 0);
    step(7); chk("rel_r17", 3'd3, 0, 0, 0);
    step(1); chk("rel_r18", 3'd4, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
